bcd_conv_sched: RTL

//  Round-robin scheduler that shares one 12-bit binary-to-BCD converter engine among NREQ requesters.

---
 rtl/bcd_conv_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin scheduler sharing one 12-bit binary-to-BCD engine
// among NREQ level-request clients. One conversion in flight at a time; the
// result is returned to the granted client with a one-cycle ack.
module bcd_conv_sched #(
  parameter int NREQ        = 4,
  parameter int EN_CYCLES   = 2,
  parameter int CONV_CYCLES = 64,
  parameter int USE_RDY     = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*12-1:0] bin_in,
  output logic [NREQ-1:0]    ack,
  output logic [15:0]        bcd_out,
  output logic               busy,
  output logic               timeout,
  output logic               conv_en,
  output logic [11:0]        conv_bin,
  input  logic [15:0]        conv_bcd,
  input  logic               conv_rdy
);

  localparam int PW      = $clog2(NREQ);
  localparam int CNT_MAX = (CONV_CYCLES > EN_CYCLES) ? CONV_CYCLES : EN_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] LAST_WAIT = CW'(CONV_CYCLES - 1);
  localparam logic [CW-1:0] LAST_EN   = CW'(EN_CYCLES - 1);
  localparam logic [PW-1:0] LAST_REQ  = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_DELIVER
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [PW-1:0] gnt_reg;
  logic [PW-1:0] rr_ptr_reg;

  // Per-client operand view of the packed operand bus.
  logic [11:0] operand [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_operand
    assign operand[gi] = bin_in[12*gi +: 12];
  end

  logic [PW-1:0] pick;
  logic          pick_valid;

  // Round-robin pick: first set request at or after rr_ptr, wrapping modulo NREQ.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr_reg) + k) % NREQ]) begin
        pick       = PW'((int'(rr_ptr_reg) + k) % NREQ);
        pick_valid = 1'b1;
      end
    end
  end

  logic          wait_last;
  logic          wait_done;
  logic [PW-1:0] next_ptr;

  // The timeout bound also ends the conversion when the ready handshake is off.
  assign wait_last = (cnt_reg == LAST_WAIT);
  assign wait_done = wait_last || ((USE_RDY != 0) && conv_rdy);
  // The client just served drops to lowest priority for the next round.
  assign next_ptr  = (gnt_reg == LAST_REQ) ? '0 : gnt_reg + 1'b1;

  // Scheduler FSM: grant, launch the engine, wait for the result, deliver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      gnt_reg    <= '0;
      rr_ptr_reg <= '0;
      ack        <= '0;
      bcd_out    <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      conv_en    <= 1'b0;
      conv_bin   <= '0;
    end else begin
      ack <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_reg   <= pick;
            conv_bin  <= operand[pick];
            busy      <= 1'b1;
            conv_en   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (cnt_reg == LAST_EN) begin
            conv_en   <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= ST_WAIT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            // A client that gave up its request gets no ack and bcd_out keeps
            // the last delivered value; the result is only committed when acked.
            if (req[gnt_reg]) begin
              ack[gnt_reg] <= 1'b1;
              bcd_out      <= conv_bcd;
            end
            if ((USE_RDY != 0) && wait_last && !conv_rdy) begin
              timeout <= 1'b1;
            end
            state_reg <= ST_DELIVER;
          end else if (!wait_last) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DELIVER: begin
          rr_ptr_reg <= next_ptr;
          busy       <= 1'b0;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
